// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: APB3-style register file, synchronised inputs, edge interrupts.
// Optional per-pin debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 16
) (
  input  logic             io_sys_clock,
  input  logic             io_sys_reset,
  input  logic             io_bus_sel,
  input  logic             io_bus_enable,
  input  logic             io_bus_write,
  input  logic [4:0]       io_bus_addr,
  input  logic [31:0]      io_bus_wdata,
  output logic [31:0]      io_bus_rdata,
  output logic             io_bus_ready,
  input  logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_pins_write,
  output logic [WIDTH-1:0] io_pins_writeEnable,
  output logic             io_irq
);

  localparam logic [2:0] IDX_IN       = 3'd0;
  localparam logic [2:0] IDX_OUT      = 3'd1;
  localparam logic [2:0] IDX_DIR      = 3'd2;
  localparam logic [2:0] IDX_RISE_EN  = 3'd3;
  localparam logic [2:0] IDX_FALL_EN  = 3'd4;
  localparam logic [2:0] IDX_PENDING  = 3'd5;
  localparam logic [2:0] IDX_DEBOUNCE = 3'd6;

  // Bus handshake: a transfer is the APB access phase (sel & enable). The slave never
  // stalls, so ready is constant 1; a write commits on the clock edge that ends the
  // access phase, and read data is combinational for the whole access phase.
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       reg_idx;
  logic [WIDTH-1:0] wdata_w;
  logic             unused_bus_bits;

  assign wr_en           = io_bus_sel & io_bus_enable & io_bus_write;
  assign rd_en           = io_bus_sel & io_bus_enable & ~io_bus_write;
  assign reg_idx         = io_bus_addr[4:2];
  assign wdata_w         = io_bus_wdata[WIDTH-1:0];
  assign unused_bus_bits = ^{io_bus_addr[1:0], io_bus_wdata};
  assign io_bus_ready    = 1'b1;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] prev_q;
  logic             irq_q;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] in_val;
  logic [31:0]      deb_rd;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= io_pins_read;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0]  deb_q;
  logic [DEB_CNT_W-1:0]  pre_q;
  logic [WIDTH-1:0]      filt_q;
  logic [WIDTH-1:0][1:0] diff_cnt_q;
  logic                  deb_wr;
  logic                  tick;

  assign deb_wr = wr_en && (reg_idx == IDX_DEBOUNCE);
  assign tick   = (deb_q != '0) && (pre_q == deb_q - DEB_CNT_W'(1));
  assign in_val = (deb_q == '0) ? synced : filt_q;
  assign deb_rd = 32'(deb_q);

  // While bypassed the filter tracks the synchroniser so enabling debounce starts clean.
  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      deb_q      <= '0;
      pre_q      <= '0;
      filt_q     <= '0;
      diff_cnt_q <= '0;
    end else if (deb_wr) begin
      deb_q      <= io_bus_wdata[DEB_CNT_W-1:0];
      pre_q      <= '0;
      diff_cnt_q <= '0;
    end else if (deb_q == '0) begin
      pre_q      <= '0;
      filt_q     <= synced;
      diff_cnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + DEB_CNT_W'(1);
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (synced[i] != filt_q[i]) begin
            if (diff_cnt_q[i] == 2'd2) begin
              filt_q[i]     <= synced[i];
              diff_cnt_q[i] <= 2'd0;
            end else begin
              diff_cnt_q[i] <= diff_cnt_q[i] + 2'd1;
            end
          end else begin
            diff_cnt_q[i] <= 2'd0;
          end
        end
      end
    end
  end
`else
  assign in_val = synced;
  assign deb_rd = '0;
`endif

  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;

  assign edge_set = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);
  assign w1c_mask = (wr_en && (reg_idx == IDX_PENDING)) ? wdata_w : '0;

  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_idx)
          IDX_OUT:     out_q     <= wdata_w;
          IDX_DIR:     dir_q     <= wdata_w;
          IDX_RISE_EN: rise_en_q <= wdata_w;
          IDX_FALL_EN: fall_en_q <= wdata_w;
          default:     ;
        endcase
      end
      prev_q    <= in_val;
      // A new edge in the same cycle as its W1C keeps the bit set.
      pending_q <= (pending_q & ~w1c_mask) | edge_set;
      irq_q     <= |(pending_q & (rise_en_q | fall_en_q));
    end
  end

  always_comb begin
    io_bus_rdata = '0;
    if (rd_en) begin
      case (reg_idx)
        IDX_IN:       io_bus_rdata = 32'(in_val);
        IDX_OUT:      io_bus_rdata = 32'(out_q);
        IDX_DIR:      io_bus_rdata = 32'(dir_q);
        IDX_RISE_EN:  io_bus_rdata = 32'(rise_en_q);
        IDX_FALL_EN:  io_bus_rdata = 32'(fall_en_q);
        IDX_PENDING:  io_bus_rdata = 32'(pending_q);
        IDX_DEBOUNCE: io_bus_rdata = deb_rd;
        default:      io_bus_rdata = '0;
      endcase
    end
  end

  assign io_pins_write       = out_q;
  assign io_pins_writeEnable = dir_q;
  assign io_irq              = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl: bus reads are scored from an expected queue by a
// monitor; pin and irq timing are checked directly. Debounce vectors need GPIO_DEBOUNCE_EN.
module tb_gpio_bank_ctrl;
  localparam int W = 8;

  localparam logic [4:0] A_IN = 5'h00, A_OUT = 5'h04, A_DIR = 5'h08, A_RISE = 5'h0C;
  localparam logic [4:0] A_FALL = 5'h10, A_PEND = 5'h14, A_DEB = 5'h18, A_NONE = 5'h1C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0, en = 1'b0, wr = 1'b0;
  logic [4:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         ready;
  logic [W-1:0] pins_in = '0;
  logic [W-1:0] pins_out, pins_oe;
  logic         irq;

  gpio_bank_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DEB_CNT_W(16)) dut (
    .io_sys_clock(clk), .io_sys_reset(rst),
    .io_bus_sel(sel), .io_bus_enable(en), .io_bus_write(wr),
    .io_bus_addr(addr), .io_bus_wdata(wdata), .io_bus_rdata(rdata), .io_bus_ready(ready),
    .io_pins_read(pins_in), .io_pins_write(pins_out), .io_pins_writeEnable(pins_oe),
    .io_irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one sample per read access phase
  always @(negedge clk) begin
    if (sel && en && !wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        check(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 sel = 1'b1; wr = 1'b1; addr = a; wdata = d; en = 1'b0;
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 sel = 1'b0; en = 1'b0; wr = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    @(posedge clk);
    #1 sel = 1'b1; wr = 1'b0; addr = a; en = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 sel = 1'b0; en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    wait_cycles(3);
    check("reset_pins_write", 32'(pins_out), 32'h0);
    check("reset_pins_oe", 32'(pins_oe), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("ready_tied", 32'(ready), 32'h1);
    rst = 1'b0;
    wait_cycles(2);
    apb_read(A_PEND, 32'h0, "reset_pending");

    // direction and output drive
    apb_write(A_DIR, 32'h0000_00FF);
    check("pins_oe_after_dir", 32'(pins_oe), 32'hFF);
    apb_write(A_OUT, 32'h0000_00A5);
    check("pins_write_after_out", 32'(pins_out), 32'hA5);
    apb_read(A_OUT, 32'hA5, "out_readback");

    // rising edge on pin0: IN after 2 cycles, PENDING next, irq one cycle later
    apb_write(A_RISE, 32'h1);
    pins_in[0] = 1'b1;
    apb_read(A_IN, 32'h01, "in_latency_pin0");
    check("irq_not_yet", 32'(irq), 32'h0);
    wait_cycles(1);
    check("irq_after_rise", 32'(irq), 32'h1);
    apb_read(A_PEND, 32'h1, "pending_rise0");

    // W1C clears, irq drops one cycle later
    apb_write(A_PEND, 32'h1);
    check("irq_at_w1c_edge", 32'(irq), 32'h1);
    wait_cycles(1);
    check("irq_after_w1c", 32'(irq), 32'h0);
    apb_read(A_PEND, 32'h0, "pending_cleared");

    // W1C coinciding with a new rise: set wins
    pins_in[0] = 1'b0;
    wait_cycles(4);
    pins_in[0] = 1'b1;
    apb_write(A_PEND, 32'h1);
    apb_read(A_PEND, 32'h1, "pending_set_wins");
    apb_write(A_PEND, 32'h1);
    apb_read(A_PEND, 32'h0, "pending_clear_again");

    // falling-edge only on pin1
    apb_write(A_RISE, 32'h0);
    apb_write(A_FALL, 32'h2);
    pins_in[1] = 1'b1;
    wait_cycles(4);
    pins_in[1] = 1'b0;
    wait_cycles(4);
    pins_in[1] = 1'b1;
    wait_cycles(4);
    apb_read(A_PEND, 32'h2, "pending_fall_only");
    apb_read(A_IN, 32'h03, "in_pins01");
    apb_read(A_NONE, 32'h0, "unmapped_read");
    check("irq_fall", 32'(irq), 32'h1);

    // enabling after the edge does not flag it
    pins_in[3] = 1'b1;
    wait_cycles(4);
    apb_write(A_RISE, 32'h8);
    wait_cycles(3);
    apb_read(A_PEND, 32'h2, "no_retro_flag");
    apb_read(A_RISE, 32'h8, "rise_en_readback");

    // bits at and above WIDTH are not stored
    apb_write(A_OUT, 32'hFFFF_FF3C);
    check("pins_write_upper_ignored", 32'(pins_out), 32'h3C);
    apb_read(A_OUT, 32'h3C, "out_upper_ignored");
    apb_read(A_FALL, 32'h2, "fall_en_readback");
    apb_read(A_DIR, 32'hFF, "dir_readback");

`ifdef GPIO_DEBOUNCE_EN
    apb_write(A_DEB, 32'h4);
    apb_read(A_DEB, 32'h4, "debounce_readback");
    pins_in[2] = 1'b1;
    wait_cycles(5);
    pins_in[2] = 1'b0;
    wait_cycles(20);
    apb_read(A_IN, 32'h0B, "debounce_rejects_pulse");
    pins_in[2] = 1'b1;
    wait_cycles(20);
    apb_read(A_IN, 32'h0F, "debounce_accepts_hold");
`else
    apb_write(A_DEB, 32'h1234);
    apb_read(A_DEB, 32'h0, "debounce_absent");
`endif

    // asynchronous reset in the middle of a read transfer
    check("irq_before_reset", 32'(irq), 32'h1);
    @(posedge clk);
    #1 sel = 1'b1; wr = 1'b0; addr = A_PEND; en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset_pins_write", 32'(pins_out), 32'h0);
    check("async_reset_pins_oe", 32'(pins_oe), 32'h0);
    check("async_reset_irq", 32'(irq), 32'h0);
    exp_q.push_back(32'h0);
    name_q.push_back("rdata_during_reset");
    en = 1'b1;
    @(posedge clk);
    #1 sel = 1'b0; en = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    apb_read(A_PEND, 32'h0, "pending_after_reset");
    apb_read(A_DIR, 32'h0, "dir_after_reset");
    apb_read(A_RISE, 32'h0, "rise_en_after_reset");
    apb_read(A_FALL, 32'h0, "fall_en_after_reset");
    check("irq_after_reset", 32'(irq), 32'h0);

    wait_cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
